// File: rtl/dlx_control.sv
// Multi-cycle DLX control sequencer covering fetch, decode, LW, SW and PC increment.
// The memory handshake uses busy: an access completes in any cycle where busy is low.
module dlx_control (
  input  logic        clk,
  input  logic        reset,
  input  logic        step_en,
  input  logic        busy,
  input  logic [31:0] data_in,
  output logic        mr,
  output logic        mw,
  output logic        gpr_we,
  output logic [2:0]  sm_state,
  output logic [4:0]  reg_address,
  output logic [9:0]  pc,
  output logic [15:0] memory_address
);

  typedef enum logic [2:0] {
    S_WAIT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_LOAD   = 3'd3,
    S_WBACK  = 3'd4,
    S_STORE  = 3'd5,
    S_INC    = 3'd6
  } state_t;

  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;

  state_t      state, nxt;
  logic [31:0] ir;
  logic [31:0] mdr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_WAIT;
      pc    <= '0;
      ir    <= '0;
      mdr   <= '0;
    end else begin
      state <= nxt;
      if (state == S_FETCH && !busy) ir  <= data_in;
      if (state == S_LOAD  && !busy) mdr <= data_in;
      if (state == S_INC)            pc  <= pc + 10'd1;
    end
  end

  always_comb begin
    nxt            = state;
    mr             = 1'b0;
    mw             = 1'b0;
    gpr_we         = 1'b0;
    memory_address = '0;
    reg_address    = ir[20:16];
    case (state)
      S_WAIT:   if (step_en) nxt = S_FETCH;
      S_FETCH: begin
        mr             = 1'b1;
        memory_address = {6'b0, pc};
        if (!busy) nxt = S_DECODE;
      end
      S_DECODE: begin
        if (ir[31:26] == OP_LW)      nxt = S_LOAD;
        else if (ir[31:26] == OP_SW) nxt = S_STORE;
        else                         nxt = S_INC;
      end
      S_LOAD: begin
        mr             = 1'b1;
        memory_address = ir[15:0];
        if (!busy) nxt = S_WBACK;
      end
      S_WBACK: begin
        gpr_we = 1'b1;
        nxt    = S_INC;
      end
      S_STORE: begin
        mw             = 1'b1;
        memory_address = ir[15:0];
        if (!busy) nxt = S_INC;
      end
      S_INC:    nxt = S_WAIT;
      default:  nxt = S_WAIT;
    endcase
  end

  assign sm_state = state;

  // MDR is the write-data source for the register file outside this block; rs is not used.
  logic _unused_ok;
  assign _unused_ok = &{1'b0, mdr, ir[25:21], 1'b0};

endmodule

// File: tb/tb_dlx_control.sv
// Directed bench for dlx_control: reset, LW with wait states, SW, NOP, reset abort, PC wrap.
module tb_dlx_control;
  logic        clk = 1'b0;
  logic        reset, step_en, busy;
  logic [31:0] data_in;
  logic        mr, mw, gpr_we;
  logic [2:0]  sm_state;
  logic [4:0]  reg_address;
  logic [9:0]  pc;
  logic [15:0] memory_address;

  int checks = 0;
  int failures = 0;

  dlx_control dut (
    .clk(clk), .reset(reset), .step_en(step_en), .busy(busy), .data_in(data_in),
    .mr(mr), .mw(mw), .gpr_we(gpr_we), .sm_state(sm_state),
    .reg_address(reg_address), .pc(pc), .memory_address(memory_address)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // read and write requests must never overlap
  always @(negedge clk)
    if (reset === 1'b1) chk("mr_mw_excl", {31'b0, mr & mw}, 32'd0);

  initial begin
    reset = 1'b0; step_en = 1'b0; busy = 1'b0; data_in = '0;
    tick(); tick();
    chk("rst_state", sm_state, 0);
    chk("rst_pc", pc, 0);
    chk("rst_ctl", {mr, mw, gpr_we}, 0);
    chk("rst_maddr", memory_address, 0);
    chk("rst_raddr", reg_address, 0);

    reset = 1'b1;
    tick();
    chk("idle_wait", sm_state, 0);

    // LW r1, 0x10 with three wait states in LOAD
    step_en = 1'b1; data_in = 32'h8C010010;
    tick();
    chk("lw_fetch_state", sm_state, 1);
    chk("lw_fetch_mr", mr, 1);
    chk("lw_fetch_addr", memory_address, 16'h0000);
    step_en = 1'b0;
    tick();
    chk("lw_decode_state", sm_state, 2);
    chk("lw_decode_ctl", {mr, mw}, 0);
    tick();
    chk("lw_load_state", sm_state, 3);
    chk("lw_load_mr", mr, 1);
    chk("lw_load_addr", memory_address, 16'h0010);
    busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lw_load_hold_state", sm_state, 3);
      chk("lw_load_hold_addr", {mr, memory_address}, {1'b1, 16'h0010});
    end
    busy = 1'b0; data_in = 32'hDEADBEEF;
    tick();
    chk("lw_wback_state", sm_state, 4);
    chk("lw_wback_we", gpr_we, 1);
    chk("lw_wback_raddr", reg_address, 1);
    chk("lw_wback_mr", mr, 0);
    chk("lw_mdr", dut.mdr, 32'hDEADBEEF);
    tick();
    chk("lw_inc_state", sm_state, 6);
    chk("lw_inc_we", gpr_we, 0);
    tick();
    chk("lw_done_state", sm_state, 0);
    chk("lw_done_pc", pc, 1);

    // SW r12, 0x20 with two wait states in STORE
    step_en = 1'b1; data_in = 32'hAC0C0020;
    tick();
    chk("sw_fetch_addr", memory_address, 16'h0001);
    step_en = 1'b0;
    tick();
    chk("sw_decode_state", sm_state, 2);
    tick();
    chk("sw_store_state", sm_state, 5);
    chk("sw_store_ctl", {mr, mw, gpr_we}, 3'b010);
    chk("sw_store_addr", memory_address, 16'h0020);
    chk("sw_store_raddr", reg_address, 12);
    busy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("sw_store_hold", {sm_state, mw, gpr_we, reg_address, memory_address},
          {3'd5, 1'b1, 1'b0, 5'd12, 16'h0020});
    end
    busy = 1'b0;
    tick();
    chk("sw_inc_state", sm_state, 6);
    chk("sw_inc_we", gpr_we, 0);
    tick();
    chk("sw_done_state", sm_state, 0);
    chk("sw_done_pc", pc, 2);

    // unknown opcode runs as a NOP
    step_en = 1'b1; data_in = 32'h00000000;
    tick();
    chk("nop_fetch", sm_state, 1);
    step_en = 1'b0;
    tick();
    chk("nop_decode", sm_state, 2);
    chk("nop_decode_ctl", {mr, mw, gpr_we}, 0);
    chk("nop_decode_addr", memory_address, 0);
    tick();
    chk("nop_inc", sm_state, 6);
    tick();
    chk("nop_done_state", sm_state, 0);
    chk("nop_done_pc", pc, 3);

    // reset in the middle of a stalled load
    step_en = 1'b1; data_in = 32'h8C010010;
    tick();
    step_en = 1'b0;
    tick(); tick();
    busy = 1'b1;
    tick();
    chk("abort_pre_state", sm_state, 3);
    reset = 1'b0;
    tick();
    chk("abort_state", sm_state, 0);
    chk("abort_mr", mr, 0);
    chk("abort_pc", pc, 0);
    reset = 1'b1; busy = 1'b0;
    tick();
    chk("abort_idle", sm_state, 0);

    // 1024 back-to-back NOP steps with step_en held high
    step_en = 1'b1; data_in = 32'h0;
    for (int i = 1; i <= 4096; i++) begin
      tick();
      if (i == 1)    chk("wrap_start_fetch", sm_state, 1);
      if (i == 4)    chk("wrap_first_wait", {22'b0, sm_state, pc}, {22'b0, 3'd0, 10'd1});
      if (i == 5)    chk("wrap_restart_fetch", sm_state, 1);
      if (i == 20)   chk("wrap_pc5", pc, 5);
      if (i == 4092) chk("wrap_pc1023", {22'b0, sm_state, pc}, {22'b0, 3'd0, 10'd1023});
    end
    chk("wrap_pc0", pc, 0);
    chk("wrap_state", sm_state, 0);
    step_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
